// File: rtl/mem_pipe_stage.sv
// Memory stage with MEM/WB latch: issues data-cache requests, formats sub-word
// loads/stores, flags misaligned accesses and latches results under stall/flush.
module mem_pipe_stage #(
  parameter int WORD_W   = 32,
  parameter int REGSEL_W = 2,
  parameter int REGBIT_W = 5
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                in_valid,
  input  logic [WORD_W-1:0]   nPC,
  input  logic [WORD_W-1:0]   ALUOut,
  input  logic [WORD_W-1:0]   storeData,
  input  logic                regWr,
  input  logic [REGSEL_W-1:0] regSel,
  input  logic [REGBIT_W-1:0] regDst,
  input  logic                memRead,
  input  logic                memWrite,
  input  logic [1:0]          memSize,
  input  logic                memSigned,
  input  logic                ihit,
  input  logic                flush,
  output logic                dmemREN,
  output logic                dmemWEN,
  output logic [WORD_W-1:0]   dmemaddr,
  output logic [WORD_W-1:0]   dmemstore,
  output logic [WORD_W/8-1:0] dmemBE,
  input  logic [WORD_W-1:0]   dmemload,
  input  logic                dhit,
  output logic                stall_out,
  output logic                valid_next,
  output logic                regWr_next,
  output logic                err_next,
  output logic [WORD_W-1:0]   nPC_next,
  output logic [WORD_W-1:0]   ALUOut_next,
  output logic [WORD_W-1:0]   dmemload_next,
  output logic [REGSEL_W-1:0] regSel_next,
  output logic [REGBIT_W-1:0] regDst_next
);

  localparam int BE_W = WORD_W / 8;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_DONE = 1'b1;

  function automatic logic [WORD_W-1:0] fmt_load(input logic [WORD_W-1:0] src,
                                                 input logic [1:0] a,
                                                 input logic [1:0] size,
                                                 input logic sgn);
    logic [WORD_W-1:0] sh;
    logic [WORD_W-1:0] r;
    sh = src >> {a, 3'b000};
    case (size)
      2'd0:    r = {{(WORD_W-8){sgn & sh[7]}}, sh[7:0]};
      2'd1:    r = {{(WORD_W-16){sgn & sh[15]}}, sh[15:0]};
      default: r = src;
    endcase
    return r;
  endfunction

  logic [0:0]          state_q, state_d;
  logic [WORD_W-1:0]   hold_q, hold_d;
  logic                valid_q, valid_d, regwr_q, regwr_d, err_q, err_d;
  logic [WORD_W-1:0]   npc_q, npc_d, alu_q, alu_d, load_q, load_d;
  logic [REGSEL_W-1:0] regsel_q, regsel_d;
  logic [REGBIT_W-1:0] regdst_q, regdst_d;

  logic              memop_s, mis_s, is_load_s, adv_s;
  logic [1:0]        a_s;
  logic [WORD_W-1:0] load_src_s, load_fmt_s;

  assign a_s       = ALUOut[1:0];
  assign memop_s   = in_valid & (memRead | memWrite);
  assign mis_s     = memop_s & (((memSize == 2'd1) & a_s[0]) |
                                ((memSize >= 2'd2) & (a_s != 2'b00)));
  assign is_load_s = in_valid & memRead & ~mis_s;
  assign dmemREN   = memop_s & memRead  & ~mis_s & (state_q == ST_IDLE);
  assign dmemWEN   = memop_s & memWrite & ~mis_s & (state_q == ST_IDLE);
  assign stall_out = memop_s & ~mis_s & (state_q == ST_IDLE) & ~dhit;
  assign adv_s     = ihit & ~stall_out;
  assign dmemaddr  = {ALUOut[WORD_W-1:2], 2'b00};

  // In DONE the hold register is authoritative; a stray dhit there is ignored.
  assign load_src_s = (state_q == ST_DONE) ? hold_q : dmemload;
  assign load_fmt_s = fmt_load(load_src_s, a_s, memSize, memSigned);

  // Store lane replication and byte-enable generation.
  always_comb begin
    dmemstore = storeData;
    dmemBE    = {BE_W{1'b1}};
    if (memWrite) begin
      case (memSize)
        2'd0: begin
          for (int i = 0; i < BE_W; i++) dmemstore[8*i +: 8] = storeData[7:0];
          dmemBE = {{(BE_W-1){1'b0}}, 1'b1} << a_s;
        end
        2'd1: begin
          for (int i = 0; i < BE_W; i++) dmemstore[8*i +: 8] = storeData[8*(i%2) +: 8];
          dmemBE = {{(BE_W-2){1'b0}}, 2'b11} << a_s;
        end
        default: begin
          dmemstore = storeData;
          dmemBE    = {BE_W{1'b1}};
        end
      endcase
    end else begin
      dmemstore = storeData;
      dmemBE    = {BE_W{1'b1}};
    end
  end

  // Completion FSM: park cache data when it returns while the pipe is frozen.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      ST_IDLE: begin
        if (memop_s & ~mis_s & dhit & ~adv_s) begin
          state_d = ST_DONE;
          hold_d  = dmemload;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DONE: begin
        if (adv_s) state_d = ST_IDLE;
        else       state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // MEM/WB latch next-state: hold, bubble or capture.
  always_comb begin
    valid_d  = valid_q;
    regwr_d  = regwr_q;
    err_d    = err_q;
    npc_d    = npc_q;
    alu_d    = alu_q;
    load_d   = load_q;
    regsel_d = regsel_q;
    regdst_d = regdst_q;
    if (adv_s) begin
      if (flush) begin
        valid_d  = 1'b0;
        regwr_d  = 1'b0;
        err_d    = 1'b0;
        npc_d    = '0;
        alu_d    = '0;
        load_d   = '0;
        regsel_d = '0;
        regdst_d = '0;
      end else begin
        valid_d  = in_valid;
        regwr_d  = regWr & in_valid & ~mis_s;
        err_d    = mis_s;
        npc_d    = nPC;
        alu_d    = ALUOut;
        load_d   = is_load_s ? load_fmt_s : '0;
        regsel_d = regSel;
        regdst_d = regDst;
      end
    end else begin
      valid_d = valid_q;
    end
  end

  // State and latch registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= ST_IDLE;
      hold_q   <= '0;
      valid_q  <= 1'b0;
      regwr_q  <= 1'b0;
      err_q    <= 1'b0;
      npc_q    <= '0;
      alu_q    <= '0;
      load_q   <= '0;
      regsel_q <= '0;
      regdst_q <= '0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      valid_q  <= valid_d;
      regwr_q  <= regwr_d;
      err_q    <= err_d;
      npc_q    <= npc_d;
      alu_q    <= alu_d;
      load_q   <= load_d;
      regsel_q <= regsel_d;
      regdst_q <= regdst_d;
    end
  end

  assign valid_next    = valid_q;
  assign regWr_next    = regwr_q;
  assign err_next      = err_q;
  assign nPC_next      = npc_q;
  assign ALUOut_next   = alu_q;
  assign dmemload_next = load_q;
  assign regSel_next   = regsel_q;
  assign regDst_next   = regdst_q;

endmodule

// File: tb/tb_mem_pipe_stage.sv
// Directed self-checking bench for mem_pipe_stage (32-bit default configuration).
module tb_mem_pipe_stage;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        in_valid;
  logic [31:0] nPC, ALUOut, storeData;
  logic        regWr;
  logic [1:0]  regSel;
  logic [4:0]  regDst;
  logic        memRead, memWrite;
  logic [1:0]  memSize;
  logic        memSigned, ihit, flush;
  logic        dmemREN, dmemWEN;
  logic [31:0] dmemaddr, dmemstore;
  logic [3:0]  dmemBE;
  logic [31:0] dmemload;
  logic        dhit, stall_out;
  logic        valid_next, regWr_next, err_next;
  logic [31:0] nPC_next, ALUOut_next, dmemload_next;
  logic [1:0]  regSel_next;
  logic [4:0]  regDst_next;

  int errors = 0;
  int checks = 0;

  mem_pipe_stage dut (
    .CLK(CLK), .nRST(nRST), .in_valid(in_valid), .nPC(nPC), .ALUOut(ALUOut),
    .storeData(storeData), .regWr(regWr), .regSel(regSel), .regDst(regDst),
    .memRead(memRead), .memWrite(memWrite), .memSize(memSize), .memSigned(memSigned),
    .ihit(ihit), .flush(flush), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore), .dmemBE(dmemBE), .dmemload(dmemload),
    .dhit(dhit), .stall_out(stall_out), .valid_next(valid_next), .regWr_next(regWr_next),
    .err_next(err_next), .nPC_next(nPC_next), .ALUOut_next(ALUOut_next),
    .dmemload_next(dmemload_next), .regSel_next(regSel_next), .regDst_next(regDst_next)
  );

  always #5 CLK = ~CLK;

  task automatic drive_idle();
    in_valid = 1'b0; nPC = 32'h0; ALUOut = 32'h0; storeData = 32'h0;
    regWr = 1'b0; regSel = 2'd0; regDst = 5'd0; memRead = 1'b0; memWrite = 1'b0;
    memSize = 2'd2; memSigned = 1'b0; ihit = 1'b1; flush = 1'b0;
    dmemload = 32'h0; dhit = 1'b0;
  endtask

  task automatic drive_load(input logic [31:0] addr, input logic [1:0] size, input logic sgn);
    drive_idle();
    in_valid = 1'b1; memRead = 1'b1; ALUOut = addr; memSize = size; memSigned = sgn;
    regWr = 1'b1; regDst = 5'd5; regSel = 2'd1; nPC = 32'h0000_0010;
  endtask

  task automatic test_reset();
    drive_idle();
    nRST = 1'b0;
    #1;
    checks++; if (valid_next !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", valid_next); end
    checks++; if (dmemload_next !== 32'h0) begin errors++; $display("FAIL rst_load got=%h exp=0", dmemload_next); end
    checks++; if ({regWr_next, err_next} !== 2'b00) begin errors++; $display("FAIL rst_flags got=%b exp=00", {regWr_next, err_next}); end
    checks++; if ({dmemREN, dmemWEN, stall_out} !== 3'b000) begin errors++; $display("FAIL rst_req got=%b exp=000", {dmemREN, dmemWEN, stall_out}); end
    @(negedge CLK); nRST = 1'b1;
  endtask

  task automatic test_word_load();
    @(negedge CLK); drive_load(32'h0000_0100, 2'd2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      if (i != 0) @(negedge CLK);
      #1;
      checks++; if ({stall_out, dmemREN} !== 2'b11) begin errors++; $display("FAIL wl_stall%0d got=%b exp=11", i, {stall_out, dmemREN}); end
      @(posedge CLK);
    end
    checks++; if (dmemaddr !== 32'h0000_0100) begin errors++; $display("FAIL wl_addr got=%h exp=00000100", dmemaddr); end
    @(negedge CLK); dhit = 1'b1; dmemload = 32'hDEAD_BEEF; #1;
    checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL wl_stall_end got=%b exp=0", stall_out); end
    checks++; if (valid_next !== 1'b0) begin errors++; $display("FAIL wl_held got=%b exp=0", valid_next); end
    @(posedge CLK); #1;
    checks++; if (dmemload_next !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wl_data got=%h exp=deadbeef", dmemload_next); end
    checks++; if ({valid_next, regWr_next, regDst_next} !== {2'b11, 5'd5}) begin errors++; $display("FAIL wl_ctl got=%b exp=1100101", {valid_next, regWr_next, regDst_next}); end
  endtask

  task automatic test_subword_load();
    @(negedge CLK); drive_load(32'h0000_0103, 2'd0, 1'b1); dhit = 1'b1; dmemload = 32'h8011_2233;
    @(posedge CLK); #1;
    checks++; if (dmemload_next !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_signed got=%h exp=ffffff80", dmemload_next); end
    @(negedge CLK); memSigned = 1'b0;
    @(posedge CLK); #1;
    checks++; if (dmemload_next !== 32'h0000_0080) begin errors++; $display("FAIL lb_unsigned got=%h exp=00000080", dmemload_next); end
    @(negedge CLK); ALUOut = 32'h0000_0102; memSize = 2'd1; memSigned = 1'b1;
    @(posedge CLK); #1;
    checks++; if (dmemload_next !== 32'hFFFF_8011) begin errors++; $display("FAIL lh_signed got=%h exp=ffff8011", dmemload_next); end
  endtask

  task automatic test_store();
    @(negedge CLK); drive_idle();
    in_valid = 1'b1; memWrite = 1'b1; memSize = 2'd1; ALUOut = 32'h0000_0102; storeData = 32'hABCD_1234;
    #1;
    checks++; if (dmemstore !== 32'h1234_1234) begin errors++; $display("FAIL sh_data got=%h exp=12341234", dmemstore); end
    checks++; if (dmemBE !== 4'b1100) begin errors++; $display("FAIL sh_be got=%b exp=1100", dmemBE); end
    checks++; if ({dmemWEN, dmemREN, stall_out} !== 3'b101) begin errors++; $display("FAIL sh_req got=%b exp=101", {dmemWEN, dmemREN, stall_out}); end
    @(negedge CLK); #1;
    checks++; if (dmemWEN !== 1'b1) begin errors++; $display("FAIL sh_hold got=%b exp=1", dmemWEN); end
    dhit = 1'b1;
    @(posedge CLK); #1;
    checks++; if ({valid_next, regWr_next, dmemload_next} !== {2'b10, 32'h0}) begin errors++; $display("FAIL sh_latch got=%h exp=200000000", {valid_next, regWr_next, dmemload_next}); end
    @(negedge CLK); memSize = 2'd0; ALUOut = 32'h0000_0101; storeData = 32'h0000_005A; #1;
    checks++; if ({dmemstore, dmemBE} !== {32'h5A5A_5A5A, 4'b0010}) begin errors++; $display("FAIL sb_fmt got=%h exp=5a5a5a5a2", {dmemstore, dmemBE}); end
    @(posedge CLK);
  endtask

  task automatic test_misaligned();
    @(negedge CLK); drive_load(32'h0000_0101, 2'd2, 1'b0); dmemload = 32'h7777_7777; #1;
    checks++; if ({dmemREN, stall_out} !== 2'b00) begin errors++; $display("FAIL mis_req got=%b exp=00", {dmemREN, stall_out}); end
    @(posedge CLK); #1;
    checks++; if ({valid_next, err_next, regWr_next} !== 3'b110) begin errors++; $display("FAIL mis_flags got=%b exp=110", {valid_next, err_next, regWr_next}); end
    checks++; if (dmemload_next !== 32'h0) begin errors++; $display("FAIL mis_data got=%h exp=0", dmemload_next); end
  endtask

  task automatic test_done_hold();
    @(negedge CLK); drive_load(32'h0000_0200, 2'd2, 1'b0); ihit = 1'b0; dhit = 1'b1; dmemload = 32'hCAFE_F00D; #1;
    checks++; if ({dmemREN, stall_out} !== 2'b10) begin errors++; $display("FAIL dn_req got=%b exp=10", {dmemREN, stall_out}); end
    @(posedge CLK); #1;
    checks++; if (err_next !== 1'b1) begin errors++; $display("FAIL dn_latch_held got=%b exp=1", err_next); end
    @(negedge CLK); dhit = 1'b0; dmemload = 32'h1111_1111; #1;
    checks++; if ({dmemREN, stall_out} !== 2'b00) begin errors++; $display("FAIL dn_norereq got=%b exp=00", {dmemREN, stall_out}); end
    @(negedge CLK); ihit = 1'b1; #1;
    checks++; if (dmemREN !== 1'b0) begin errors++; $display("FAIL dn_norereq2 got=%b exp=0", dmemREN); end
    @(posedge CLK); #1;
    checks++; if ({valid_next, err_next, dmemload_next} !== {2'b10, 32'hCAFE_F00D}) begin errors++; $display("FAIL dn_data got=%h exp=2cafef00d", {valid_next, err_next, dmemload_next}); end
    @(negedge CLK); ihit = 1'b0; #1;
    checks++; if (dmemREN !== 1'b1) begin errors++; $display("FAIL dn_back_idle got=%b exp=1", dmemREN); end
  endtask

  task automatic test_flush();
    @(negedge CLK); drive_load(32'h0000_0300, 2'd2, 1'b0); flush = 1'b1; #1;
    checks++; if ({dmemREN, stall_out} !== 2'b11) begin errors++; $display("FAIL fl_req got=%b exp=11", {dmemREN, stall_out}); end
    @(posedge CLK); #1;
    checks++; if ({valid_next, dmemload_next} !== {1'b1, 32'hCAFE_F00D}) begin errors++; $display("FAIL fl_hold got=%h exp=1cafef00d", {valid_next, dmemload_next}); end
    @(negedge CLK); #1;
    checks++; if (dmemREN !== 1'b1) begin errors++; $display("FAIL fl_req_kept got=%b exp=1", dmemREN); end
    dhit = 1'b1; dmemload = 32'h1234_5678;
    @(posedge CLK); #1;
    checks++; if ({valid_next, regWr_next, err_next, nPC_next, ALUOut_next, dmemload_next, regSel_next, regDst_next} !== 106'h0) begin
      errors++; $display("FAIL fl_bubble got=%h exp=0", {valid_next, regWr_next, err_next, nPC_next, ALUOut_next, dmemload_next, regSel_next, regDst_next});
    end
  endtask

  task automatic test_reset_mid();
    @(negedge CLK); drive_idle(); in_valid = 1'b1; regWr = 1'b1; nPC = 32'h0000_0044; regDst = 5'd7;
    @(posedge CLK); #1;
    checks++; if ({valid_next, regWr_next, nPC_next, regDst_next} !== {2'b11, 32'h44, 5'd7}) begin errors++; $display("FAIL nm_latch got=%h exp=%h", {valid_next, regWr_next, nPC_next, regDst_next}, {2'b11, 32'h44, 5'd7}); end
    @(negedge CLK); drive_load(32'h0000_0400, 2'd2, 1'b0); #1;
    checks++; if (dmemREN !== 1'b1) begin errors++; $display("FAIL rm_req got=%b exp=1", dmemREN); end
    #2; nRST = 1'b0; in_valid = 1'b0; #1;
    checks++; if ({valid_next, regWr_next, nPC_next, regDst_next} !== 39'h0) begin errors++; $display("FAIL rm_latch got=%h exp=0", {valid_next, regWr_next, nPC_next, regDst_next}); end
    checks++; if ({dmemREN, stall_out} !== 2'b00) begin errors++; $display("FAIL rm_req_drop got=%b exp=00", {dmemREN, stall_out}); end
    @(negedge CLK); nRST = 1'b1;
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_subword_load();
    test_store();
    test_misaligned();
    test_done_hold();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
